// File: rtl/tagged_register_file_if.sv
// Interface bundling the decode/issue, ROB commit and read-port signals of
// the tagged register file. The core side drives through the master modport,
// the register file sits on the slave modport. Clock and reset stay outside.
interface tagged_register_file_if #(
    parameter int XLEN      = 32,
    parameter int REG_IDX_W = 5,
    parameter int TAG_W     = 4
);
    logic                 rdy_in;
    logic                 flush_pipline;

    logic [REG_IDX_W-1:0] rs1_reg_id;
    logic [XLEN-1:0]      rs1_val;
    logic                 rs1_busy;
    logic [TAG_W-1:0]     rs1_tag;

    logic [REG_IDX_W-1:0] rs2_reg_id;
    logic [XLEN-1:0]      rs2_val;
    logic                 rs2_busy;
    logic [TAG_W-1:0]     rs2_tag;

    logic                 is_issuing_rd;
    logic [REG_IDX_W-1:0] issue_rd_id;
    logic [TAG_W-1:0]     issue_tag;

    logic                 is_committing_rd;
    logic [REG_IDX_W-1:0] commit_rd_id;
    logic [TAG_W-1:0]     commit_tag;
    logic [XLEN-1:0]      commit_val;

    modport master (
        output rdy_in, flush_pipline,
        output rs1_reg_id, rs2_reg_id,
        input  rs1_val, rs1_busy, rs1_tag,
        input  rs2_val, rs2_busy, rs2_tag,
        output is_issuing_rd, issue_rd_id, issue_tag,
        output is_committing_rd, commit_rd_id, commit_tag, commit_val
    );

    modport slave (
        input  rdy_in, flush_pipline,
        input  rs1_reg_id, rs2_reg_id,
        output rs1_val, rs1_busy, rs1_tag,
        output rs2_val, rs2_busy, rs2_tag,
        input  is_issuing_rd, issue_rd_id, issue_tag,
        input  is_committing_rd, commit_rd_id, commit_tag, commit_val
    );
endinterface

// File: rtl/tagged_register_file.sv
// Architectural register file with per-register rename tags.
// Issue marks a destination busy with its ROB tag; commit writes the value
// and releases busy only when the committing tag still owns the register.
// Flush clears every busy bit. Register 0 is hard-wired to zero.
// Optional feature: define REGFILE_BYPASS_EN to forward a same-cycle commit
// onto the read ports; otherwise reads see pre-edge state only.
module tagged_register_file #(
    parameter int XLEN      = 32,
    parameter int NREG      = 32,
    parameter int REG_IDX_W = 5,
    parameter int TAG_W     = 4
) (
    input  logic clk_in,
    input  logic rst_n_in,
    tagged_register_file_if.slave bus
);

    logic [XLEN-1:0]  val_q  [NREG];
    logic [XLEN-1:0]  val_d  [NREG];
    logic [NREG-1:0]  busy_q;
    logic [NREG-1:0]  busy_d;
    logic [TAG_W-1:0] tag_q  [NREG];
    logic [TAG_W-1:0] tag_d  [NREG];

    logic commit_ok;
    logic issue_ok;

    logic [REG_IDX_W-1:0] rd_id   [2];
    logic [XLEN-1:0]      rd_val  [2];
    logic                 rd_busy [2];
    logic [TAG_W-1:0]     rd_tag  [2];

    // Qualify issue and commit: frozen when not ready, x0 and out-of-range indices dropped, flush kills issue.
    always_comb begin
        commit_ok = bus.rdy_in && bus.is_committing_rd
                    && (bus.commit_rd_id != '0) && (int'(bus.commit_rd_id) < NREG);
        issue_ok  = bus.rdy_in && bus.is_issuing_rd && !bus.flush_pipline
                    && (bus.issue_rd_id != '0) && (int'(bus.issue_rd_id) < NREG);
    end

    // Next-state: flush clears busy, commit writes value and releases a matching tag, issue wins last.
    always_comb begin
        val_d  = val_q;
        busy_d = busy_q;
        tag_d  = tag_q;
        if (bus.rdy_in && bus.flush_pipline) begin
            busy_d = '0;
        end
        if (commit_ok) begin
            val_d[bus.commit_rd_id] = bus.commit_val;
            if (busy_q[bus.commit_rd_id] && (tag_q[bus.commit_rd_id] == bus.commit_tag)) begin
                busy_d[bus.commit_rd_id] = 1'b0;
            end
        end
        if (issue_ok) begin
            busy_d[bus.issue_rd_id] = 1'b1;
            tag_d[bus.issue_rd_id]  = bus.issue_tag;
        end
    end

    // State registers with asynchronous clear of value, busy and tag.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < NREG; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                val_q[i] <= val_d[i];
                tag_q[i] <= tag_d[i];
            end
            busy_q <= busy_d;
        end
    end

    // Combinational read ports: x0 and out-of-range read as zero, optional commit forwarding.
    always_comb begin
        rd_id[0] = bus.rs1_reg_id;
        rd_id[1] = bus.rs2_reg_id;
        for (int p = 0; p < 2; p++) begin
            rd_val[p]  = '0;
            rd_busy[p] = 1'b0;
            rd_tag[p]  = '0;
            if ((rd_id[p] != '0) && (int'(rd_id[p]) < NREG)) begin
                rd_val[p]  = val_q[rd_id[p]];
                rd_busy[p] = busy_q[rd_id[p]];
                rd_tag[p]  = tag_q[rd_id[p]];
`ifdef REGFILE_BYPASS_EN
                if (commit_ok && (bus.commit_rd_id == rd_id[p])) begin
                    rd_val[p] = bus.commit_val;
                    if (busy_q[rd_id[p]] && (tag_q[rd_id[p]] == bus.commit_tag)) begin
                        rd_busy[p] = 1'b0;
                    end
                end
`endif
            end
        end
    end

    assign bus.rs1_val  = rd_val[0];
    assign bus.rs1_busy = rd_busy[0];
    assign bus.rs1_tag  = rd_tag[0];
    assign bus.rs2_val  = rd_val[1];
    assign bus.rs2_busy = rd_busy[1];
    assign bus.rs2_tag  = rd_tag[1];

endmodule

// File: tb/tb_tagged_register_file.sv
// Directed self-checking bench for tagged_register_file.
// Inputs are driven 1 time unit after the rising edge and outputs are checked
// there too, so every check sits away from the active clock edge.
module tb_tagged_register_file;

    localparam int XLEN      = 32;
    localparam int NREG      = 32;
    localparam int REG_IDX_W = 5;
    localparam int TAG_W     = 4;

    logic clk_in;
    logic rst_n_in;

    int compared   = 0;
    int mismatched = 0;

    tagged_register_file_if #(.XLEN(XLEN), .REG_IDX_W(REG_IDX_W), .TAG_W(TAG_W)) bus ();

    tagged_register_file #(
        .XLEN(XLEN), .NREG(NREG), .REG_IDX_W(REG_IDX_W), .TAG_W(TAG_W)
    ) dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .bus      (bus)
    );

    // Free-running 10-unit clock.
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", name, observed, expected);
        end
    endtask

    task automatic idle();
        bus.flush_pipline    = 1'b0;
        bus.is_issuing_rd    = 1'b0;
        bus.issue_rd_id      = '0;
        bus.issue_tag        = '0;
        bus.is_committing_rd = 1'b0;
        bus.commit_rd_id     = '0;
        bus.commit_tag       = '0;
        bus.commit_val       = '0;
    endtask

    // Advance one clock and land 1 unit after the edge with controls idle.
    task automatic applyStimulus();
        @(posedge clk_in);
        #1;
        idle();
    endtask

    task automatic setIssue(input logic [4:0] id, input logic [3:0] tag);
        bus.is_issuing_rd = 1'b1;
        bus.issue_rd_id   = id;
        bus.issue_tag     = tag;
    endtask

    task automatic setCommit(input logic [4:0] id, input logic [3:0] tag, input logic [31:0] val);
        bus.is_committing_rd = 1'b1;
        bus.commit_rd_id     = id;
        bus.commit_tag       = tag;
        bus.commit_val       = val;
    endtask

    task automatic readRegs(input logic [4:0] id1, input logic [4:0] id2);
        bus.rs1_reg_id = id1;
        bus.rs2_reg_id = id2;
        #1;
    endtask

    initial begin
        rst_n_in       = 1'b0;
        bus.rdy_in     = 1'b1;
        bus.rs1_reg_id = 5'd5;
        bus.rs2_reg_id = 5'd7;
        idle();
        #2;
        checkOutput("reset_rs1_val", bus.rs1_val, 32'h0);
        checkOutput("reset_rs1_busy", 32'(bus.rs1_busy), 32'h0);
        checkOutput("reset_rs2_tag", 32'(bus.rs2_tag), 32'h0);
        @(posedge clk_in);
        @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;

        // Test 1: commit to a not-busy register
        readRegs(5'd5, 5'd0);
        checkOutput("t1_x5_val_init", bus.rs1_val, 32'h0);
        checkOutput("t1_x5_busy_init", 32'(bus.rs1_busy), 32'h0);
        setCommit(5'd5, 4'd3, 32'hDEADBEEF);
        applyStimulus();
        readRegs(5'd5, 5'd0);
        checkOutput("t1_x5_val", bus.rs1_val, 32'hDEADBEEF);
        checkOutput("t1_x5_busy", 32'(bus.rs1_busy), 32'h0);

        // Test 2: issue then matching commit
        setIssue(5'd7, 4'd2);
        applyStimulus();
        readRegs(5'd7, 5'd0);
        checkOutput("t2_x7_busy_issue", 32'(bus.rs1_busy), 32'h1);
        checkOutput("t2_x7_tag_issue", 32'(bus.rs1_tag), 32'h2);
        setCommit(5'd7, 4'd2, 32'h11);
        applyStimulus();
        readRegs(5'd7, 5'd0);
        checkOutput("t2_x7_busy_commit", 32'(bus.rs1_busy), 32'h0);
        checkOutput("t2_x7_val_commit", bus.rs1_val, 32'h11);

        // Test 3: stale commit keeps the younger owner
        setIssue(5'd7, 4'd2);
        applyStimulus();
        setIssue(5'd7, 4'd5);
        applyStimulus();
        setCommit(5'd7, 4'd2, 32'h22);
        applyStimulus();
        readRegs(5'd7, 5'd0);
        checkOutput("t3_x7_val_stale", bus.rs1_val, 32'h22);
        checkOutput("t3_x7_busy_stale", 32'(bus.rs1_busy), 32'h1);
        checkOutput("t3_x7_tag_stale", 32'(bus.rs1_tag), 32'h5);
        setCommit(5'd7, 4'd5, 32'h33);
        applyStimulus();
        readRegs(5'd7, 5'd0);
        checkOutput("t3_x7_busy_final", 32'(bus.rs1_busy), 32'h0);
        checkOutput("t3_x7_val_final", bus.rs1_val, 32'h33);

        // Test 4: flush with simultaneous issue and commit
        setIssue(5'd1, 4'd1);
        applyStimulus();
        setIssue(5'd2, 4'd2);
        applyStimulus();
        setIssue(5'd3, 4'd3);
        applyStimulus();
        readRegs(5'd1, 5'd3);
        checkOutput("t4_x1_busy_pre", 32'(bus.rs1_busy), 32'h1);
        checkOutput("t4_x3_tag_pre", 32'(bus.rs2_tag), 32'h3);
        bus.flush_pipline = 1'b1;
        setIssue(5'd4, 4'd4);
        setCommit(5'd2, 4'd2, 32'h44);
        applyStimulus();
        readRegs(5'd1, 5'd3);
        checkOutput("t4_x1_busy_flush", 32'(bus.rs1_busy), 32'h0);
        checkOutput("t4_x3_busy_flush", 32'(bus.rs2_busy), 32'h0);
        readRegs(5'd4, 5'd2);
        checkOutput("t4_x4_busy_flush", 32'(bus.rs1_busy), 32'h0);
        checkOutput("t4_x2_val_flush", bus.rs2_val, 32'h44);
        checkOutput("t4_x2_busy_flush", 32'(bus.rs2_busy), 32'h0);

        // Issue and commit to the same register in one cycle: value written, issue wins
        setIssue(5'd6, 4'd7);
        setCommit(5'd6, 4'd7, 32'h66);
        applyStimulus();
        readRegs(5'd6, 5'd0);
        checkOutput("same_x6_val", bus.rs1_val, 32'h66);
        checkOutput("same_x6_busy", 32'(bus.rs1_busy), 32'h1);
        checkOutput("same_x6_tag", 32'(bus.rs1_tag), 32'h7);

        // Test 5: read coinciding with a commit to the same register
        setIssue(5'd9, 4'd1);
        applyStimulus();
        setCommit(5'd9, 4'd1, 32'h55);
        readRegs(5'd9, 5'd0);
`ifdef REGFILE_BYPASS_EN
        checkOutput("t5_x9_val_same", bus.rs1_val, 32'h55);
        checkOutput("t5_x9_busy_same", 32'(bus.rs1_busy), 32'h0);
`else
        checkOutput("t5_x9_val_same", bus.rs1_val, 32'h0);
        checkOutput("t5_x9_busy_same", 32'(bus.rs1_busy), 32'h1);
`endif
        checkOutput("t5_x9_tag_same", 32'(bus.rs1_tag), 32'h1);
        applyStimulus();
        readRegs(5'd9, 5'd0);
        checkOutput("t5_x9_val_next", bus.rs1_val, 32'h55);
        checkOutput("t5_x9_busy_next", 32'(bus.rs1_busy), 32'h0);

        // Test 6a: x0 ignores issue and commit
        setIssue(5'd0, 4'd9);
        setCommit(5'd0, 4'd9, 32'h99);
        applyStimulus();
        readRegs(5'd0, 5'd0);
        checkOutput("t6_x0_val", bus.rs1_val, 32'h0);
        checkOutput("t6_x0_busy", 32'(bus.rs1_busy), 32'h0);
        checkOutput("t6_x0_tag", 32'(bus.rs2_tag), 32'h0);

        // Test 6b: rdy_in low freezes issue, commit and flush
        setIssue(5'd11, 4'd8);
        applyStimulus();
        bus.rdy_in = 1'b0;
        setIssue(5'd5, 4'd6);
        setCommit(5'd5, 4'd3, 32'h77);
        applyStimulus();
        bus.flush_pipline = 1'b1;
        setCommit(5'd11, 4'd8, 32'hAA);
        applyStimulus();
        bus.rdy_in = 1'b1;
        readRegs(5'd5, 5'd11);
        checkOutput("t6_frozen_x5_val", bus.rs1_val, 32'hDEADBEEF);
        checkOutput("t6_frozen_x5_busy", 32'(bus.rs1_busy), 32'h0);
        checkOutput("t6_frozen_x11_busy", 32'(bus.rs2_busy), 32'h1);
        checkOutput("t6_frozen_x11_val", bus.rs2_val, 32'h0);

        // Test 6c: asynchronous reset in the middle of a burst
        setIssue(5'd12, 4'd3);
        applyStimulus();
        setIssue(5'd13, 4'd4);
        setCommit(5'd7, 4'd0, 32'hBB);
        readRegs(5'd12, 5'd7);
        checkOutput("t6_x12_busy_pre", 32'(bus.rs1_busy), 32'h1);
        rst_n_in = 1'b0;
        #1;
        checkOutput("t6_async_x12_busy", 32'(bus.rs1_busy), 32'h0);
        checkOutput("t6_async_x7_val", bus.rs2_val, 32'h0);
        applyStimulus();
        rst_n_in = 1'b1;
        readRegs(5'd13, 5'd2);
        checkOutput("t6_post_x13_busy", 32'(bus.rs1_busy), 32'h0);
        checkOutput("t6_post_x2_val", bus.rs2_val, 32'h0);
        readRegs(5'd7, 5'd11);
        checkOutput("t6_post_x7_val", bus.rs1_val, 32'h0);
        checkOutput("t6_post_x11_busy", 32'(bus.rs2_busy), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
